// File: rtl/fft_frame_feeder.sv
// Frame feeder between a non-stallable sample source and an AXI-Stream FFT input.
// Buffers samples in a small FWFT FIFO after configuration and marks frame boundaries with tlast.
module fft_frame_feeder #(
  parameter int DATA_W     = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_done,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample_data,
  output logic [DATA_W-1:0] o_m_axis_tdata,
  output logic              o_m_axis_tvalid,
  input  logic              i_m_axis_tready,
  output logic              o_m_axis_tlast,
  output logic              o_overflow,
  output logic [15:0]       o_frame_count,
  output logic              o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX_C = IW'(FRAME_LEN - 1);

  typedef enum logic {WAIT_CFG = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              full, wr_en, rd_en;

  // Full is judged on registered occupancy only, so a same-cycle read never makes room.
  always_comb begin
    full     = (cnt_q == DEPTH_C);
    rd_en    = (cnt_q != '0) && i_m_axis_tready;
    wr_en    = (state_q == RUN) && i_sample_valid && !full;
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    fcnt_d   = fcnt_q;
    if (state_q == WAIT_CFG && i_cfg_done) state_d = RUN;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      idx_d    = idx_q + 1'b1;
      if (idx_q == LAST_IDX_C) fcnt_d = fcnt_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (state_q == RUN && i_sample_valid && full) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= WAIT_CFG;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) mem_q[wr_ptr_q] <= i_sample_data;
  end

  assign o_m_axis_tdata  = mem_q[rd_ptr_q];
  assign o_m_axis_tvalid = (cnt_q != '0);
  assign o_m_axis_tlast  = (cnt_q != '0) && (idx_q == LAST_IDX_C);
  assign o_overflow      = ovf_q;
  assign o_frame_count   = fcnt_q;
  assign o_busy          = (state_q == RUN);

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomized self-checking bench for fft_frame_feeder against a queue-based reference model.
module tb_fft_frame_feeder;

  localparam int DATA_W     = 32;
  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 4;

  logic              i_clk;
  logic              i_rst;
  logic              i_cfg_done;
  logic              i_sample_valid;
  logic [DATA_W-1:0] i_sample_data;
  logic [DATA_W-1:0] o_m_axis_tdata;
  logic              o_m_axis_tvalid;
  logic              i_m_axis_tready;
  logic              o_m_axis_tlast;
  logic              o_overflow;
  logic [15:0]       o_frame_count;
  logic              o_busy;

  fft_frame_feeder #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cfg_done     (i_cfg_done),
    .i_sample_valid (i_sample_valid),
    .i_sample_data  (i_sample_data),
    .o_m_axis_tdata (o_m_axis_tdata),
    .o_m_axis_tvalid(o_m_axis_tvalid),
    .i_m_axis_tready(i_m_axis_tready),
    .o_m_axis_tlast (o_m_axis_tlast),
    .o_overflow     (o_overflow),
    .o_frame_count  (o_frame_count),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_run;
  bit          m_ovf;
  logic [15:0] m_fc;
  int          m_idx;

  // Handshaked output stream, recorded for ordering/tlast checks
  logic [31:0] got_d[$];
  bit          got_l[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit c, input bit r, input bit rs);
    bit          do_rd, do_wr, do_drop, stalled;
    logic [31:0] pre_data;
    bit          pre_last;
    i_rst           = rs;
    i_cfg_done      = c;
    i_sample_valid  = v;
    i_sample_data   = d;
    i_m_axis_tready = r;
    do_rd    = (m_q.size() != 0) && r;
    do_wr    = m_run && v && (m_q.size() < FIFO_DEPTH);
    do_drop  = m_run && v && (m_q.size() >= FIFO_DEPTH);
    stalled  = (m_q.size() != 0) && !r && !rs;
    pre_data = o_m_axis_tdata;
    pre_last = o_m_axis_tlast;
    @(posedge i_clk);
    #1;
    if (rs) begin
      m_q.delete();
      m_run = 0;
      m_ovf = 0;
      m_fc  = '0;
      m_idx = 0;
    end else begin
      if (do_rd) begin
        got_d.push_back(pre_data);
        got_l.push_back(pre_last);
        void'(m_q.pop_front());
        if (m_idx == FRAME_LEN - 1) m_fc = m_fc + 16'd1;
        m_idx = (m_idx + 1) % FRAME_LEN;
      end
      if (do_wr) m_q.push_back(d);
      if (do_drop) m_ovf = 1;
      if (!m_run && c) m_run = 1;
    end
    check_eq("tvalid", 32'(o_m_axis_tvalid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("tdata", o_m_axis_tdata, m_q[0]);
    check_eq("tlast", 32'(o_m_axis_tlast), 32'((m_q.size() != 0) && (m_idx == FRAME_LEN - 1)));
    check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
    check_eq("frame_count", 32'(o_frame_count), 32'(m_fc));
    check_eq("busy", 32'(o_busy), 32'(m_run));
    if (stalled) check_eq("stall_tdata", o_m_axis_tdata, pre_data);
  endtask

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    i_rst = 1'b1; i_cfg_done = 1'b0; i_sample_valid = 1'b0;
    i_sample_data = '0; i_m_axis_tready = 1'b1;
    m_run = 0; m_ovf = 0; m_fc = '0; m_idx = 0;

    cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h1234, 1, 1, 1);

    // No configuration: everything is discarded
    for (int i = 0; i < 20; i++) cycle(1, $urandom, 0, 1, 0);
    check_eq("wait_busy", 32'(o_busy), 32'd0);
    check_eq("wait_ovf", 32'(o_overflow), 32'd0);

    // cfg_done with a coincident sample (dropped), then 16 samples back to back
    cycle(1, 32'hDEAD, 1, 1, 0);
    clear_got();
    for (int i = 0; i < 16; i++) cycle(1, 32'(i), 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    check_eq("seq_count", 32'(got_d.size()), 32'd16);
    for (int i = 0; i < got_d.size() && i < 16; i++) begin
      check_eq("seq_data", got_d[i], 32'(i));
      check_eq("seq_last", 32'(got_l[i]), 32'((i % 8) == 7));
    end
    check_eq("seq_fc", 32'(o_frame_count), 32'd2);

    // Overflow with stalled sink
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 32'hA + 32'(i), 0, 0, 0);
    check_eq("ovf_set", 32'(o_overflow), 32'd1);
    clear_got();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
    check_eq("ovf_count", 32'(got_d.size()), 32'd4);
    for (int i = 0; i < got_d.size() && i < 4; i++) check_eq("ovf_data", got_d[i], 32'hA + 32'(i));

    // Full FIFO with simultaneous read and write: the write is still dropped
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(1, 32'(i), 0, 0, 0);
    check_eq("full_ovf_pre", 32'(o_overflow), 32'd0);
    clear_got();
    cycle(1, 32'h55, 0, 1, 0);
    check_eq("full_ovf", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
    check_eq("full_count", 32'(got_d.size()), 32'd4);
    for (int i = 0; i < got_d.size() && i < 4; i++) check_eq("full_data", got_d[i], 32'(i + 1));

    // Random valid/ready over 10 frames
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    clear_got();
    guard = 0;
    while (m_fc < 16'd10 && guard < 4000) begin
      cycle(bit'($urandom_range(0, 1)), $urandom, 0, bit'($urandom_range(0, 1)), 0);
      guard++;
    end
    check_eq("rand_fc", 32'(o_frame_count), 32'd10);
    for (int i = 0; i < got_l.size() && i < 80; i++)
      check_eq("rand_last", 32'(got_l[i]), 32'((i % 8) == 7));

    // Reset mid-frame after 5 samples of a frame have been output
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 1, 1, 0);
    clear_got();
    for (int i = 0; i < 5; i++) cycle(1, 32'h100 + 32'(i), 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check_eq("mid_count", 32'(got_d.size()), 32'd5);
    cycle(1, 32'h1FF, 1, 1, 1);
    check_eq("mid_rst_tvalid", 32'(o_m_axis_tvalid), 32'd0);
    check_eq("mid_rst_fc", 32'(o_frame_count), 32'd0);
    cycle(0, 0, 1, 1, 0);
    clear_got();
    for (int i = 0; i < 8; i++) cycle(1, 32'h200 + 32'(i), 0, 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0);
    check_eq("post_count", 32'(got_d.size()), 32'd8);
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      check_eq("post_data", got_d[i], 32'h200 + 32'(i));
      check_eq("post_last", 32'(got_l[i]), 32'(i == 7));
    end
    check_eq("post_fc", 32'(o_frame_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_feeder.md
FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 Parameter DATA_W, default 32, width of one complex sample (imag in [31:16], real in [15:0]); passed through unmodified.
REQ-002 Parameter FRAME_LEN, default 1024, samples per FFT frame, power of two, range 8..65536.
REQ-003 Parameter FIFO_DEPTH, default 16, buffer entries, power of two, range 4..256.
REQ-004 i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_cfg_done  input  1  one-cycle pulse from the FFT config stage indicating the core configuration has been issued.
REQ-007 i_sample_valid  input  1  input sample strobe; the source cannot be stalled.
REQ-008 i_sample_data  input  DATA_W  input sample, qualified by i_sample_valid.
REQ-009 o_m_axis_tdata  output  DATA_W  sample to the FFT data input channel.
REQ-010 o_m_axis_tvalid  output  1  AXI-Stream valid.
REQ-011 i_m_axis_tready  input  1  AXI-Stream ready from the FFT core.
REQ-012 o_m_axis_tlast  output  1  marks the last sample of each FRAME_LEN-sample frame.
REQ-013 o_overflow  output  1  sticky flag; at least one input sample was dropped because the FIFO was full.
REQ-014 o_frame_count  output  16  number of completed output frames, modulo 2^16.
REQ-015 o_busy  output  1  high in state RUN.

Function
REQ-016 The block SHALL implement a two-state FSM: WAIT_CFG (reset state) and RUN.
REQ-017 WAIT_CFG -> RUN on the cycle after i_cfg_done is sampled high; RUN -> WAIT_CFG only on reset; i_cfg_done in RUN is ignored.
REQ-018 In WAIT_CFG every input sample is discarded; a sample valid in the same cycle as i_cfg_done is discarded; o_overflow is not set.
REQ-019 In RUN, a sample with i_sample_valid high is written to the FIFO when the registered occupancy is below FIFO_DEPTH.
REQ-020 When occupancy equals FIFO_DEPTH, the sample is dropped and o_overflow is set, even if a read handshake occurs in the same cycle (no full-bypass).
REQ-021 The FIFO is first-word-fall-through: o_m_axis_tvalid = (occupancy != 0); o_m_axis_tdata = head entry.
REQ-022 Write-to-output latency: a sample written into an empty FIFO at edge N appears with tvalid high after edge N, i.e. in cycle N+1.
REQ-023 A read handshake occurs when o_m_axis_tvalid and i_m_axis_tready are both high; the head entry is then removed.
REQ-024 Simultaneous write and read: occupancy is unchanged and both pointers advance; pointers wrap modulo FIFO_DEPTH.
REQ-025 While tvalid is high and tready is low, tdata, tvalid and tlast SHALL remain stable.
REQ-026 An output index counter (log2 FRAME_LEN bits) increments on each read handshake and wraps from FRAME_LEN-1 to 0.
REQ-027 o_m_axis_tlast = tvalid AND (output index == FRAME_LEN-1).
REQ-028 o_frame_count increments by 1 on each handshake with tlast high; it wraps from 65535 to 0.
REQ-029 Dropped samples do not affect the output index; frame length on the stream is always exactly FRAME_LEN handshakes.
REQ-030 An input sample is never duplicated, reordered or modified.

Reset
REQ-031 With i_rst high at a clock edge, state = WAIT_CFG; FIFO occupancy, pointers, output index = 0; o_overflow = 0; o_frame_count = 0.
REQ-032 During and after reset: o_m_axis_tvalid = 0, o_m_axis_tlast = 0, o_busy = 0; o_m_axis_tdata is don't-care while tvalid = 0.
REQ-033 Reset mid-frame discards FIFO contents and the partial frame; the next frame after a new i_cfg_done starts at index 0.
REQ-034 i_rst has priority over i_cfg_done and all other inputs in the same cycle.

Verification
REQ-035 FRAME_LEN=8, tready=1: no cfg_done, 20 valid samples -> tvalid stays 0, o_busy=0, o_overflow=0.
REQ-036 FRAME_LEN=8, tready=1: cfg_done pulse, then samples 0x0..0xF every cycle -> output 0x0..0xF in order, tlast on 0x7 and 0xF, o_frame_count=2.
REQ-037 FIFO_DEPTH=4, tready=0, RUN: 6 consecutive samples A..F -> A..D stored, E,F dropped, o_overflow=1; raise tready -> exactly A,B,C,D out.
REQ-038 FIFO_DEPTH=4, FIFO full, tready=1 and new sample in same cycle -> new sample dropped, o_overflow=1, occupancy 3 next cycle.
REQ-039 FRAME_LEN=8: random tready (50%) over 10 frames -> data stable while stalled, tlast every 8th handshake, o_frame_count=10.
REQ-040 Assert i_rst after 5 of 8 frame samples output -> next cycle tvalid=0, o_frame_count=0; after cfg_done, first output sample has index 0 and tlast on 8th.
